// File: rtl/glip_loopback_engine.sv
// GLIP loopback/test engine: buffered FWFT datapath between the host->FPGA and
// FPGA->host streams with loopback, inverted loopback, pattern generator and
// pattern checker modes, plus transfer and error statistics.
module glip_loopback_engine #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic                   clr_stats,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [1:0]             active_mode,
    output logic [$clog2(DEPTH):0] fill,
    output logic [CNT_WIDTH-1:0]   rx_count,
    output logic [CNT_WIDTH-1:0]   tx_count,
    output logic [15:0]            err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] M_LOOP   = 2'd0;
    localparam logic [1:0] M_INVERT = 2'd1;
    localparam logic [1:0] M_GEN    = 2'd2;
    localparam logic [1:0] M_CHECK  = 2'd3;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] pat;
    logic [WIDTH-1:0] exp_word;
    logic             full;
    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             in_xfer;
    logic             out_xfer;
    logic             load_mode;
    logic             chk_xfer;
    logic             gen_push;

    // Error counter saturates instead of wrapping so long runs never hide errors.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign fill      = wptr - rptr;
    assign full      = (fill == (AW+1)'(DEPTH));
    assign out_valid = !rst && (fill != '0);
    assign out_data  = mem[rptr[AW-1:0]];
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign chk_xfer  = in_xfer && (active_mode == M_CHECK);
    assign gen_push  = push && (active_mode == M_GEN);

    // Per-mode input acceptance and buffer write selection; nothing moves in DRAIN.
    always_comb begin
        in_ready  = 1'b0;
        push      = 1'b0;
        push_data = in_data;
        if (!rst && state == RUN) begin
            case (active_mode)
                M_LOOP: begin
                    in_ready = !full;
                    push     = in_valid && !full;
                end
                M_INVERT: begin
                    in_ready  = !full;
                    push      = in_valid && !full;
                    push_data = ~in_data;
                end
                M_GEN: begin
                    in_ready  = 1'b1;
                    push      = !full;
                    push_data = pat;
                end
                default: begin
                    in_ready = 1'b1;
                end
            endcase
        end
    end

    // Next state: leave RUN on a mode request, return once the buffer is empty.
    always_comb begin
        state_next = state;
        load_mode  = 1'b0;
        case (state)
            RUN: begin
                if (mode != active_mode) state_next = DRAIN;
            end
            DRAIN: begin
                if (fill == '0) begin
                    state_next = RUN;
                    load_mode  = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    // Buffer storage; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= push_data;
    end

    // Pointers, mode register, pattern generator and checker expectation.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            active_mode <= mode;
            pat         <= '0;
            exp_word    <= '0;
        end else begin
            if (push)     wptr <= wptr + (AW+1)'(1);
            if (out_xfer) rptr <= rptr + (AW+1)'(1);
            if (load_mode) begin
                active_mode <= mode;
                pat         <= '0;
                exp_word    <= '0;
            end else begin
                if (gen_push) pat      <= pat + WIDTH'(1);
                if (chk_xfer) exp_word <= in_data + WIDTH'(1);
            end
        end
    end

    // Statistics; a clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            rx_count  <= '0;
            tx_count  <= '0;
            err_count <= '0;
        end else begin
            if (in_xfer)  rx_count <= rx_count + CNT_WIDTH'(1);
            if (out_xfer) tx_count <= tx_count + CNT_WIDTH'(1);
            if (chk_xfer && (in_data != exp_word)) err_count <= sat_inc(err_count);
        end
    end

endmodule

// File: tb/tb_glip_loopback_engine.sv
// Bench for glip_loopback_engine: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, and a WIDTH=8 generator
// instance for pattern wrap-around.
module tb_glip_loopback_engine;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        clr_stats = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  active_mode;
    logic [4:0]  fill;
    logic [31:0] rx_count;
    logic [31:0] tx_count;
    logic [15:0] err_count;

    logic [7:0]  in_data8 = '0;
    logic        in_ready8;
    logic [7:0]  out_data8;
    logic        out_valid8;
    logic [1:0]  active_mode8;
    logic [2:0]  fill8;
    logic [7:0]  rx_count8;
    logic [7:0]  tx_count8;
    logic [15:0] err_count8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    glip_loopback_engine #(.WIDTH(16), .DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .mode(mode), .clr_stats(clr_stats),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .active_mode(active_mode), .fill(fill), .rx_count(rx_count),
        .tx_count(tx_count), .err_count(err_count)
    );

    glip_loopback_engine #(.WIDTH(8), .DEPTH(4), .CNT_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .mode(2'd2), .clr_stats(1'b0),
        .in_data(in_data8), .in_valid(1'b0), .in_ready(in_ready8),
        .out_data(out_data8), .out_valid(out_valid8), .out_ready(1'b1),
        .active_mode(active_mode8), .fill(fill8), .rx_count(rx_count8),
        .tx_count(tx_count8), .err_count(err_count8)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] q[$];
    logic [15:0] obs[$];
    logic [1:0]  m_act = 2'd0;
    logic        m_drain = 1'b0;
    logic [15:0] m_pat = '0;
    logic [15:0] m_exp = '0;
    logic [31:0] m_rx = '0;
    logic [31:0] m_tx = '0;
    logic [15:0] m_err = '0;
    bit          started = 0;
    int          m_sz;
    logic        m_acc;
    logic        m_pop;
    logic        m_push;
    logic [15:0] m_word;

    function automatic logic model_in_ready();
        return !m_drain && ((m_act >= 2'd2) || (q.size() < DEPTH));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_act = mode; m_drain = 1'b0; m_pat = '0; m_exp = '0;
            m_rx = '0; m_tx = '0; m_err = '0;
            started = 1;
        end else begin
            m_sz   = q.size();
            m_acc  = in_valid && model_in_ready();
            m_pop  = (m_sz > 0) && out_ready;
            m_push = 1'b0;
            m_word = '0;
            if (!m_drain) begin
                case (m_act)
                    2'd0: if (m_acc) begin m_push = 1'b1; m_word = in_data; end
                    2'd1: if (m_acc) begin m_push = 1'b1; m_word = ~in_data; end
                    2'd2: if (m_sz < DEPTH) begin m_push = 1'b1; m_word = m_pat; m_pat = m_pat + 16'd1; end
                    default: if (m_acc) begin
                        if (in_data != m_exp && m_err != 16'hFFFF) m_err = m_err + 16'd1;
                        m_exp = in_data + 16'd1;
                    end
                endcase
            end
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(m_word);
            if (m_acc) m_rx = m_rx + 32'd1;
            if (m_pop) m_tx = m_tx + 32'd1;
            if (clr_stats) begin m_rx = '0; m_tx = '0; m_err = '0; end
            if (m_drain) begin
                if (m_sz == 0) begin
                    m_act = mode; m_pat = '0; m_exp = '0; m_drain = 1'b0;
                end
            end else if (mode != m_act) begin
                m_drain = 1'b1;
            end
        end
        if (out_valid && out_ready) obs.push_back(out_data);
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", in_ready, !rst && model_in_ready());
            chk("out_valid", out_valid, !rst && (q.size() > 0));
            if (!rst && q.size() > 0) chk("out_data", out_data, q[0]);
            chk("fill", fill, q.size());
            chk("active_mode", active_mode, m_act);
            chk("rx_count", rx_count, m_rx);
            chk("tx_count", tx_count, m_tx);
            chk("err_count", err_count, m_err);
        end
    end

    // WIDTH=8 generator: continuous count that wraps 0xFF -> 0x00.
    logic [7:0] exp8 = '0;
    logic [7:0] prev8 = '0;
    bit         wrap_seen = 0;

    always @(posedge clk) begin
        if (rst) exp8 <= '0;
        else if (out_valid8) exp8 <= exp8 + 8'd1;
    end

    always @(negedge clk) begin
        if (started && !rst && out_valid8) begin
            chk("gen8", out_data8, exp8);
            if (prev8 == 8'hFF && out_data8 == 8'h00) wrap_seen = 1;
            prev8 = out_data8;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        int t;
        in_data  = w;
        in_valid = 1'b1;
        t = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                chk("send_timeout", in_ready, 1'b1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_active(input logic [1:0] m);
        int t;
        t = 0;
        while (t < 100) begin
            @(negedge clk);
            if (active_mode == m) break;
            t++;
        end
        chk("wait_active", active_mode, m);
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] obs_at(input int i);
        return (obs.size() > i) ? 64'(obs[i]) : 64'hFFFF_FFFF;
    endfunction

    task automatic pulse_clr();
        clr_stats = 1'b1;
        @(posedge clk); #1;
        clr_stats = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        // Reset state
        rst = 1'b1; mode = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_fill", fill, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rx", rx_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // LOOP 0x0001..0x0040
        out_ready = 1'b1;
        for (int i = 1; i <= 64; i++) send(16'(i));
        idle(4);
        chk("loop_rx", rx_count, 64);
        chk("loop_tx", tx_count, 64);
        chk("loop_err", err_count, 0);
        chk("loop_cnt", obs.size(), 64);
        for (int i = 0; i < 64; i++) chk("loop_word", obs_at(i), i + 1);

        // LOOP backpressure
        pulse_clr();
        obs.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(16'h0100 + 16'(i));
        in_data = 16'h0110; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_fill", fill, 16);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_rx", rx_count, 16);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 16; i < 20; i++) send(16'h0100 + 16'(i));
        idle(24);
        chk("bp_cnt", obs.size(), 20);
        for (int i = 0; i < 20; i++) chk("bp_word", obs_at(i), 16'h0100 + i);

        // INVERT
        obs.delete();
        mode = 2'd1;
        wait_active(2'd1);
        send(16'h00FF);
        send(16'hA5A5);
        idle(4);
        chk("inv_w0", obs_at(0), 16'hFF00);
        chk("inv_w1", obs_at(1), 16'h5A5A);

        // LOOP -> GEN with 5 words held
        mode = 2'd0;
        wait_active(2'd0);
        obs.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(16'h0021 + 16'(i));
        mode = 2'd2;
        @(negedge clk);
        @(negedge clk);
        chk("sw_in_ready", in_ready, 0);
        chk("sw_active", active_mode, 0);
        repeat (3) @(negedge clk);
        chk("sw_fill", fill, 5);
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle(14);
        chk("sw_active_gen", active_mode, 2);
        for (int i = 0; i < 5; i++) chk("sw_loop_word", obs_at(i), 16'h0021 + i);
        for (int i = 0; i < 5; i++) chk("sw_gen_word", obs_at(5 + i), i);

        // CHECK
        obs.delete();
        mode = 2'd3;
        wait_active(2'd3);
        pulse_clr();
        send(16'd0); send(16'd1); send(16'd2); send(16'd7); send(16'd8); send(16'd3);
        @(negedge clk);
        chk("chk_err", err_count, 2);
        chk("chk_out_valid", out_valid, 0);
        chk("chk_rx", rx_count, 6);
        @(posedge clk); #1;
        in_data = 16'h0055; in_valid = 1'b1; clr_stats = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; clr_stats = 1'b0;
        @(negedge clk);
        chk("chk_clr_err", err_count, 0);
        @(posedge clk); #1;

        // Reset during GEN with fill=10
        mode = 2'd2;
        wait_active(2'd2);
        out_ready = 1'b0;
        t = 0;
        while (t < 100) begin
            @(negedge clk);
            if (fill == 5'd9) break;
            t++;
        end
        chk("pre_rst_fill", fill, 9);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("in_rst_fill", fill, 10);
        chk("in_rst_out_valid", out_valid, 0);
        chk("in_rst_in_ready", in_ready, 0);
        @(negedge clk);
        chk("rst_fill0", fill, 0);
        chk("rst_tx0", tx_count, 0);
        chk("rst_rx0", rx_count, 0);
        chk("rst_err0", err_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        obs.delete();
        out_ready = 1'b1;
        idle(8);
        chk("rst_gen_w0", obs_at(0), 0);
        chk("rst_gen_w1", obs_at(1), 1);
        chk("rst_gen_w2", obs_at(2), 2);

        // Let the 8-bit generator run through a wrap
        idle(300);
        chk("gen8_wrap", wrap_seen, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
